// File: rtl/lab2v1_pio_irq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lab2v1_pio_irq_sequencer : Avalon-MM master servicing an edge-capture PIO
// Rev 1.0
// ============================================================================
module lab2v1_pio_irq_sequencer #(
  parameter int                DATA_W    = 10,
  parameter logic [DATA_W-1:0] MASK_INIT = {DATA_W{1'b1}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              pio_irq,
  input  logic              enable,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_mask_load,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_edges,
  output logic [DATA_W-1:0] evt_data,
  output logic [CNT_W-1:0]  evt_count,
  output logic              busy
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT_MASK = 3'd0,
    S_IDLE      = 3'd1,
    S_WR_MASK   = 3'd2,
    S_RD_CAP    = 3'd3,
    S_CLR_CAP   = 3'd4,
    S_RD_DATA   = 3'd5,
    S_LAT_DATA  = 3'd6,
    S_PRESENT   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic [1:0]          addr_q, addr_d;
  logic [31:0]         wd_q, wd_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   edges_q, edges_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   rd_data;
  logic                readdata_unused;

  assign rd_data         = m_readdata[DATA_W-1:0];
  assign readdata_unused = &{1'b0, m_readdata};

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    edges_d = edges_q;
    data_d  = data_q;
    count_d = count_q;

    if (cfg_mask_load) begin
      pend_d = 1'b1;
      mask_d = cfg_mask;
    end

    case (state_q)
      // Stays one idle cycle after reset, then holds while its write is on the bus.
      S_INIT_MASK: if (cs_q) state_d = S_IDLE;
      S_IDLE: begin
        if (pend_q)                  state_d = S_WR_MASK;
        else if (enable && pio_irq)  state_d = S_RD_CAP;
      end
      S_WR_MASK: begin
        if (!cfg_mask_load) pend_d = 1'b0;
        state_d = S_IDLE;
      end
      S_RD_CAP:  state_d = S_CLR_CAP;
      S_CLR_CAP: begin
        edges_d = rd_data;
        state_d = (rd_data == '0) ? S_IDLE : S_RD_DATA;
      end
      S_RD_DATA: state_d = S_LAT_DATA;
      S_LAT_DATA: begin
        data_d  = rd_data;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (evt_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT_MASK;
    endcase
  end

  // Bus signals are registered from the next state so each bus cycle lines up with its state.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 2'd0;
    wd_d   = '0;
    case (state_d)
      S_INIT_MASK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_MASK;
        wd_d[DATA_W-1:0] = MASK_INIT;
      end
      S_WR_MASK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_MASK;
        wd_d[DATA_W-1:0] = mask_d;
      end
      S_RD_CAP:  begin cs_d = 1'b1; addr_d = ADDR_EDGE; end
      S_CLR_CAP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_EDGE; end
      S_RD_DATA: begin cs_d = 1'b1; addr_d = ADDR_DATA; end
      default: ;
    endcase
    valid_d = (state_d == S_PRESENT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT_MASK;
      pend_q  <= 1'b0;
      mask_q  <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      addr_q  <= 2'd0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      edges_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      edges_q <= edges_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wn_q;
  assign m_writedata  = wd_q;
  assign evt_valid    = valid_q;
  assign evt_edges    = edges_q;
  assign evt_data     = data_q;
  assign evt_count    = count_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lab2v1_pio_irq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_lab2v1_pio_irq_sequencer : PIO slave model, script-based reference, checks
// Rev 1.0
// ============================================================================
module tb_lab2v1_pio_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [31:0] m_writedata, m_readdata;
  logic        pio_irq;
  logic        enable = 1'b1;
  logic [9:0]  cfg_mask = '0;
  logic        cfg_mask_load = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [9:0]  evt_edges, evt_data;
  logic [15:0] evt_count;
  logic        busy;

  always #5 clk = ~clk;

  lab2v1_pio_irq_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .pio_irq(pio_irq),
    .enable(enable), .cfg_mask(cfg_mask), .cfg_mask_load(cfg_mask_load),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
    .evt_data(evt_data), .evt_count(evt_count), .busy(busy)
  );

  // PIO slave: registered readdata, write to edge_capture clears it.
  logic [9:0]  pio_edge = '0, pio_mask = '0, port_data = '0, inject = '0;
  logic        force_irq = 1'b0;
  logic [31:0] pio_rd = '0;

  always @(posedge clk) begin
    if (m_chipselect && m_write_n) begin
      case (m_address)
        2'd0:    pio_rd <= {22'h2A5A5A, port_data};
        2'd2:    pio_rd <= {22'h2A5A5A, pio_mask};
        2'd3:    pio_rd <= {22'h2A5A5A, pio_edge};
        default: pio_rd <= 32'hDEAD_BEEF;
      endcase
    end
    if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[9:0];
    if (m_chipselect && !m_write_n && m_address == 2'd3) pio_edge <= inject;
    else                                                 pio_edge <= pio_edge | inject;
  end

  assign m_readdata = pio_rd;
  assign pio_irq    = (|(pio_edge & pio_mask)) | force_irq;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each cycle is one scripted operation; an irq pushes the service script.
  localparam int OP_IDLE = 0, OP_NOP = 1, OP_WRI = 2, OP_WRM = 3, OP_RD3 = 4,
                 OP_WR3  = 5, OP_RD0 = 6, OP_LAT = 7, OP_PRES = 8;

  function automatic logic [35:0] bus_of(input int op, input logic [9:0] wv);
    case (op)
      OP_WRI:  return {1'b1, 1'b0, 2'd2, 32'h3FF};
      OP_WRM:  return {1'b1, 1'b0, 2'd2, 22'd0, wv};
      OP_RD3:  return {1'b1, 1'b1, 2'd3, 32'd0};
      OP_WR3:  return {1'b1, 1'b0, 2'd3, 32'd0};
      OP_RD0:  return {1'b1, 1'b1, 2'd0, 32'd0};
      default: return {1'b0, 1'b1, 2'd0, 32'd0};
    endcase
  endfunction

  initial begin
    int         cur = OP_NOP;
    int         nxt;
    int         script[$];
    logic       pend = 1'b0;
    logic [9:0] pend_val = '0, wval = '0, cap_e = '0, cap_d = '0;
    logic [9:0] x_edges = '0, x_data = '0;
    logic [15:0] x_count = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cur = OP_NOP; script = {OP_WRI};
        pend = 1'b0; x_edges = '0; x_data = '0; x_count = '0;
      end
      chk("bus", {m_chipselect, m_write_n, m_address, m_writedata}, bus_of(cur, wval));
      chk("busy", busy, cur != OP_IDLE);
      chk("evt_valid", evt_valid, cur == OP_PRES);
      chk("evt_edges", evt_edges, x_edges);
      chk("evt_data", evt_data, x_data);
      chk("evt_count", evt_count, x_count);
      if (reset_n) begin
        nxt = OP_IDLE;
        case (cur)
          OP_IDLE: begin
            if (pend) begin
              wval = cfg_mask_load ? cfg_mask : pend_val;
              nxt  = OP_WRM;
            end else if (enable && pio_irq) begin
              nxt    = OP_RD3;
              script = {OP_WR3, OP_RD0, OP_LAT, OP_PRES};
            end
          end
          OP_RD3: cap_e = pio_edge;
          OP_WR3: begin
            x_edges = cap_e;
            if (cap_e == '0) script.delete();
          end
          OP_RD0: cap_d = port_data;
          OP_LAT: x_data = cap_d;
          OP_PRES: if (evt_ready) x_count++;
          default: ;
        endcase
        if (cur != OP_IDLE) begin
          if (cur == OP_PRES && !evt_ready) nxt = OP_PRES;
          else if (script.size() > 0)       nxt = script.pop_front();
          else                              nxt = OP_IDLE;
        end
        if (cur == OP_WRM) pend = 1'b0;
        if (cfg_mask_load) begin
          pend = 1'b1; pend_val = cfg_mask;
        end
        cur = nxt;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      if (evt_valid) begin ok = 1'b1; break; end
      n++;
    end
  endtask

  task automatic wait_mask_wr(input int limit, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      if (m_chipselect && !m_write_n && m_address == 2'd2) begin ok = 1'b1; break; end
      n++;
    end
  endtask

  initial begin
    bit ok;
    int lat;
    int rcnt = 0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset release: one idle cycle, one mask write of 0x3FF, then idle.
    @(negedge clk);
    chk("lit_init_nop_cs", m_chipselect, 1'b0);
    @(negedge clk);
    chk("lit_init_wr", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b1, 1'b0, 2'd2, 32'h3FF});
    @(negedge clk);
    chk("lit_idle_busy", busy, 1'b0);
    chk("lit_idle_evt", {evt_valid, evt_edges, evt_data, evt_count}, 37'd0);

    // Basic event with latency measurement.
    tick(); port_data = 10'h2A5; inject = 10'h005;
    tick(); inject = '0;
    @(negedge clk);
    lat = 0;
    while (!evt_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("lit_latency", lat, 5);
    chk("lit_edges1", evt_edges, 10'h005);
    chk("lit_data1", evt_data, 10'h2A5);
    tick();
    @(negedge clk);
    chk("lit_count1", evt_count, 16'd1);
    chk("lit_valid_drop", evt_valid, 1'b0);

    // Back-pressure hold with an irq raised during the hold.
    tick(); evt_ready = 1'b0; port_data = 10'h155; inject = 10'h100;
    tick(); inject = '0;
    wait_valid(20, ok);
    chk("hold_wait_valid", ok, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) port_data = 10'h0AA;
      if (i == 3) inject = 10'h020;
      if (i == 4) inject = '0;
      @(negedge clk);
      chk("lit_hold", {evt_valid, evt_edges, evt_data, m_chipselect}, {1'b1, 10'h100, 10'h155, 1'b0});
    end
    tick(); evt_ready = 1'b1;
    tick();
    wait_valid(30, ok);
    chk("second_wait_valid", ok, 1'b1);
    chk("lit_edges2", evt_edges, 10'h020);
    chk("lit_data2", evt_data, 10'h0AA);
    tick();
    @(negedge clk);
    chk("lit_count3", evt_count, 16'd3);

    // Spurious irq: edge_capture reads zero.
    tick(); force_irq = 1'b1;
    tick(); force_irq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lit_spur_valid", evt_valid, 1'b0);
    end
    chk("lit_spur_count", evt_count, 16'd3);

    // Two mask loads mid-sequence; the last one is written after the event.
    tick(); inject = 10'h003; port_data = 10'h1C3;
    tick(); inject = '0;
    tick();
    tick();
    tick(); cfg_mask = 10'h0F0; cfg_mask_load = 1'b1;
    tick(); cfg_mask = 10'h00F;
    tick(); cfg_mask_load = 1'b0;
    wait_mask_wr(20, ok);
    chk("maskwr_seen", ok, 1'b1);
    chk("lit_maskwr_data", m_writedata, 32'h00F);
    chk("lit_count4", evt_count, 16'd4);

    // Reset during CLR_CAP.
    tick(); inject = 10'h001;
    tick(); inject = '0;
    tick();
    tick(); reset_n = 1'b0;
    #1;
    chk("lit_rst_cs", m_chipselect, 1'b0);
    chk("lit_rst_valid", evt_valid, 1'b0);
    chk("lit_rst_busy", busy, 1'b1);
    tick(); reset_n = 1'b1;
    wait_mask_wr(10, ok);
    chk("rst_maskwr_seen", ok, 1'b1);
    chk("lit_rst_maskwr", m_writedata, 32'h3FF);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) reset_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        rcnt = $urandom_range(1, 3);
      end
      evt_ready     = ($urandom_range(0, 99) < 60);
      enable        = ($urandom_range(0, 99) < 92);
      cfg_mask_load = ($urandom_range(0, 99) < 4);
      cfg_mask      = 10'($urandom);
      inject        = ($urandom_range(0, 99) < 12) ? (10'($urandom) & 10'($urandom)) : 10'd0;
      port_data     = 10'($urandom);
      force_irq     = ($urandom_range(0, 99) < 2);
    end
    tick();
    reset_n = 1'b1; inject = '0; force_irq = 1'b0; cfg_mask_load = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
